// File: rtl/display_dogm240.sv
// display_dogm240: 960-word framebuffer plus SPI refresh engine for the EA DOGM240
// (240x64 mono LCD, UC1611s). Resets the panel, sends the init block once, then
// streams page commands and page data for pages 0..7 continuously.
module display_dogm240 #(
    parameter int CLK_DIV         = 1,
    parameter int RST_LOW_CYCLES  = 16,
    parameter int RST_WAIT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [9:0]  addr_in,
    input  logic [15:0] data_in,
    input  logic        we_in,
    output logic        disp_cs_n_o,
    output logic        disp_res_n_o,
    output logic        disp_data_o,
    output logic        disp_addr_o,
    output logic        disp_sck_o
);
    localparam int FB_WORDS   = 960;
    localparam int PAGE_WORDS = 120;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {RES_LOW, RES_WAIT, INIT, PAGE_CMD, PAGE_DATA} state_t;
    typedef enum logic [1:0] {PH_START, PH_BIT, PH_GAP} phase_t;

    state_t           state;
    state_t           state_next;
    phase_t           phase;
    logic [15:0]      wait_cnt;
    logic [7:0]       idx;        // byte index inside the current state
    logic [2:0]       page;
    logic [3:0]       half_cnt;   // sck half-period number inside a byte, 0..15
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      fb [FB_WORDS];
    logic [15:0]      rd_word;
    logic [9:0]       rd_addr;
    logic [7:0]       tx_byte;
    logic             sending;
    logic             byte_done;

    // Fixed UC1611s init block, sent once after the panel reset.
    function automatic logic [7:0] init_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 8'hF1;
            4'd1:    return 8'h3F;
            4'd2:    return 8'hF2;
            4'd3:    return 8'h00;
            4'd4:    return 8'hF3;
            4'd5:    return 8'h3F;
            4'd6:    return 8'h81;
            4'd7:    return 8'hB7;
            4'd8:    return 8'hC0;
            4'd9:    return 8'h02;
            4'd10:   return 8'hA3;
            4'd11:   return 8'hE9;
            4'd12:   return 8'hA9;
            4'd13:   return 8'hD1;
            4'd14:   return 8'h89;
            default: return 8'h00;
        endcase
    endfunction

    assign sending   = (state == INIT) || (state == PAGE_CMD) || (state == PAGE_DATA);
    assign byte_done = sending && (phase == PH_GAP);
    // Even column -> low byte, odd column -> high byte of the same word.
    assign rd_addr   = 10'(page) * 10'(PAGE_WORDS) + {3'b000, idx[7:1]};

    // Framebuffer: host write port and engine read port; the engine samples once per data byte.
    // NOTE: the framebuffer has no reset so it maps onto block RAM and survives reset_in.
    // NOTE: non-blocking assignments make the engine read return the pre-write word (read-first).
    always_ff @(posedge clk_in) begin
        if (we_in && (addr_in < 10'(FB_WORDS))) fb[addr_in] <= data_in;
        if ((state == PAGE_DATA) && (phase == PH_START)) rd_word <= fb[rd_addr];
    end

    // State register.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state <= RES_LOW;
        else           state <= state_next;
    end

    // Next-state logic: reset timing, then init block, then page command/data forever.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            RES_LOW:   if (wait_cnt == 16'(RST_LOW_CYCLES - 1))  state_next = RES_WAIT;
            RES_WAIT:  if (wait_cnt == 16'(RST_WAIT_CYCLES - 1)) state_next = INIT;
            INIT:      if (byte_done && (idx == 8'd14))          state_next = PAGE_CMD;
            PAGE_CMD:  if (byte_done && (idx == 8'd3))           state_next = PAGE_DATA;
            PAGE_DATA: if (byte_done && (idx == 8'd239))         state_next = PAGE_CMD;
            default:                                             state_next = RES_LOW;
        endcase
    end

    // Sequencing counters: reset delays, byte index within a state, current page.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wait_cnt <= '0;
            idx      <= '0;
            page     <= '0;
        end else begin
            if (state_next != state) wait_cnt <= '0;
            else if (!sending)       wait_cnt <= wait_cnt + 16'd1;
            if (byte_done) begin
                idx <= (state_next != state) ? 8'd0 : idx + 8'd1;
                if ((state == PAGE_DATA) && (state_next == PAGE_CMD)) page <= page + 3'd1;
            end
        end
    end

    // Byte framing: one start clock, 16 sck half-periods of CLK_DIV clocks, one gap clock.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            phase    <= PH_START;
            half_cnt <= '0;
            div_cnt  <= '0;
        end else if (sending) begin
            case (phase)
                PH_START: begin
                    phase    <= PH_BIT;
                    half_cnt <= '0;
                    div_cnt  <= '0;
                end
                PH_BIT: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (half_cnt == 4'd15) phase <= PH_GAP;
                        else                   half_cnt <= half_cnt + 4'd1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: phase <= PH_START;
            endcase
        end
    end

    // Output decode: byte selection and panel pins from state and byte phase.
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            INIT: tx_byte = init_byte(idx[3:0]);
            PAGE_CMD: begin
                case (idx[1:0])
                    2'd0:    tx_byte = {5'b01100, page};
                    2'd1:    tx_byte = 8'h70;
                    2'd2:    tx_byte = 8'h00;
                    default: tx_byte = 8'h10;
                endcase
            end
            PAGE_DATA: tx_byte = idx[0] ? rd_word[15:8] : rd_word[7:0];
            default:   tx_byte = 8'h00;
        endcase
        disp_cs_n_o  = !(sending && (phase != PH_GAP));
        disp_res_n_o = (state != RES_LOW);
        disp_addr_o  = (state == PAGE_DATA);
        disp_sck_o   = !(sending && (phase == PH_BIT) && !half_cnt[0]);
        disp_data_o  = sending && (phase == PH_BIT) && tx_byte[3'd7 - half_cnt[3:1]];
    end

endmodule

// File: tb/tb_display_dogm240.sv
// tb_display_dogm240: captures the SPI stream and compares every byte against a
// frame-level model (init list, page header arithmetic, framebuffer array).
module tb_display_dogm240;
    localparam int INIT_BYTES  = 15;
    localparam int PAGE_BYTES  = 244;
    localparam int FRAME_BYTES = 8 * PAGE_BYTES;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [9:0]  addr_in;
    logic [15:0] data_in;
    logic        we_in;
    logic        disp_cs_n_o;
    logic        disp_res_n_o;
    logic        disp_data_o;
    logic        disp_addr_o;
    logic        disp_sck_o;

    always #5 clk_in = ~clk_in;

    display_dogm240 dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .we_in        (we_in),
        .disp_cs_n_o  (disp_cs_n_o),
        .disp_res_n_o (disp_res_n_o),
        .disp_data_o  (disp_data_o),
        .disp_addr_o  (disp_addr_o),
        .disp_sck_o   (disp_sck_o)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] fb_model [960];
    logic [7:0]  init_seq [INIT_BYTES] = '{8'hF1, 8'h3F, 8'hF2, 8'h00, 8'hF3, 8'h3F, 8'h81, 8'hB7,
                                           8'hC0, 8'h02, 8'hA3, 8'hE9, 8'hA9, 8'hD1, 8'h89};
    int          exp_n = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Expected {cd, byte} for stream position n since reset release.
    function automatic logic [8:0] exp_byte(input int n);
        int k, p, o, col;
        logic [15:0] w;
        if (n < INIT_BYTES) return {1'b0, init_seq[n]};
        k = (n - INIT_BYTES) % FRAME_BYTES;
        p = k / PAGE_BYTES;
        o = k % PAGE_BYTES;
        if (o == 0) return {1'b0, 8'h60 | 8'(p)};
        if (o == 1) return {1'b0, 8'h70};
        if (o == 2) return {1'b0, 8'h00};
        if (o == 3) return {1'b0, 8'h10};
        col = o - 4;
        w = fb_model[p * 120 + col / 2];
        return {1'b1, (col % 2 == 1) ? w[15:8] : w[7:0]};
    endfunction

    function automatic int cur_page();
        if (exp_n < INIT_BYTES) return 0;
        return ((exp_n - INIT_BYTES) % FRAME_BYTES) / PAGE_BYTES;
    endfunction

    // Random writes must not touch the page being sent or the one right after it.
    function automatic bit page_ok(input int p);
        int c;
        c = cur_page();
        return (p != c) && (p != (c + 1) % 8);
    endfunction

    // SPI monitor, sampled on the falling clk edge.
    int         cyc = 0;
    int         last_fall = -1;
    logic       prev_cs_n = 1'b1;
    logic       prev_sck = 1'b1;
    logic [7:0] shift = 8'h00;
    int         nbits = 0;
    logic       cd_start = 1'b0;
    logic       cd_bad = 1'b0;
    logic       sck_idle_bad = 1'b0;
    logic [8:0] exp_v;

    always @(negedge clk_in) begin
        cyc++;
        if (!reset_in) begin
            prev_cs_n = 1'b1;
            prev_sck  = 1'b1;
            nbits     = 0;
            last_fall = -1;
            cd_bad    = 1'b0;
            exp_n     = 0;
        end else begin
            if (prev_cs_n && !disp_cs_n_o) begin
                if (last_fall >= 0) check("byte_period", cyc - last_fall, 18);
                last_fall = cyc;
                nbits     = 0;
                shift     = 8'h00;
                cd_start  = disp_addr_o;
                cd_bad    = 1'b0;
            end
            if (!disp_cs_n_o) begin
                if (disp_addr_o != cd_start) cd_bad = 1'b1;
                if (!prev_sck && disp_sck_o) begin
                    shift = {shift[6:0], disp_data_o};
                    nbits++;
                end
            end else if (!disp_sck_o) begin
                sck_idle_bad = 1'b1;
            end
            if (!prev_cs_n && disp_cs_n_o) begin
                exp_v = exp_byte(exp_n);
                check($sformatf("byte%0d_val", exp_n), shift, exp_v[7:0]);
                check($sformatf("byte%0d_cd", exp_n), cd_start, exp_v[8]);
                check($sformatf("byte%0d_bits", exp_n), nbits, 8);
                check($sformatf("byte%0d_cd_stable", exp_n), cd_bad, 1'b0);
                exp_n++;
            end
            prev_cs_n = disp_cs_n_o;
            prev_sck  = disp_sck_o;
        end
    end

    task automatic write_word(input int a, input logic [15:0] d);
        @(negedge clk_in);
        #1;
        addr_in = 10'(a);
        data_in = d;
        we_in   = 1'b1;
        if (a < 960) fb_model[a] = d;
        @(posedge clk_in);
        #1;
        we_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},  disp_cs_n_o,  1'b1);
        check({tag, "_res_n"}, disp_res_n_o, 1'b0);
        check({tag, "_data"},  disp_data_o,  1'b0);
        check({tag, "_cd"},    disp_addr_o,  1'b0);
        check({tag, "_sck"},   disp_sck_o,   1'b1);
    endtask

    initial begin
        int n;
        int a;
        logic [15:0] d;
        reset_in = 1'b0;
        we_in    = 1'b0;
        addr_in  = '0;
        data_in  = '0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("rst0");

        // Clear the framebuffer, then preload words, all while reset is held.
        for (int i = 0; i < 960; i++) write_word(i, 16'h0000);
        write_word(0, 16'hA55A);
        write_word(121, 16'h1234);
        write_word(960, 16'hFFFF);
        write_word(1023, 16'hFFFF);
        check_reset_outputs("rst1");

        @(negedge clk_in);
        #2 reset_in = 1'b1;
        n = 0;
        while (!disp_res_n_o && n < 200) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        check("res_low_cycles", n, 16);
        n = 0;
        while (disp_cs_n_o && n < 200) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        check("res_wait_cycles", n, 16);

        // One full frame plus the start of the next, with random host writes.
        n = 0;
        while (exp_n < INIT_BYTES + FRAME_BYTES + 8 && n < 45000) begin
            @(negedge clk_in);
            #1;
            we_in = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                a = int'($urandom_range(0, 1023));
                d = 16'($urandom);
                if (a >= 960 || page_ok(a / 120)) begin
                    addr_in = 10'(a);
                    data_in = d;
                    we_in   = 1'b1;
                    if (a < 960) fb_model[a] = d;
                end
            end
            n++;
        end
        we_in = 1'b0;
        check("frame_done", exp_n >= INIT_BYTES + FRAME_BYTES + 8, 1'b1);

        // Abort in the middle of a data byte.
        n = 0;
        while (!(disp_addr_o && !disp_cs_n_o && !disp_sck_o) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        check("found_data_byte", disp_addr_o && !disp_cs_n_o, 1'b1);
        #2 reset_in = 1'b0;
        #1;
        check_reset_outputs("abort");
        write_word(5, 16'hBEEF);
        repeat (4) @(negedge clk_in);
        #2 reset_in = 1'b1;

        // Replay: init block again, then pages 0 and 1 from the retained framebuffer.
        n = 0;
        while (exp_n < INIT_BYTES + 2 * PAGE_BYTES && n < 20000) begin
            @(negedge clk_in);
            n++;
        end
        check("replay_done", exp_n >= INIT_BYTES + 2 * PAGE_BYTES, 1'b1);
        check("sck_idle_high", sck_idle_bad, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_dogm240.md
Name: display_dogm240

Overview:
Framebuffer and serial refresh engine for the EA DOGM240 (240x64 mono LCD, UC1611s controller, 4-wire SPI). The host CPU writes 16-bit words into an internal 960-word framebuffer. The engine resets the panel, sends a fixed init sequence, then streams the framebuffer to the panel forever. It sits between the calculator core's display-memory write bus and the LCD pins.

Parameters:
CLK_DIV, 1, system clocks per SCK half-period (SCK = clk_in/(2*CLK_DIV)).
RST_LOW_CYCLES, 16, clocks disp_res_n_o is held low after reset release.
RST_WAIT_CYCLES, 16, clocks waited after disp_res_n_o rises before the first init byte.

Ports:
clk_in  in  1  system clock (5 MHz nominal)
reset_in  in  1  asynchronous active-low reset
addr_in  in  10  framebuffer word address
data_in  in  16  framebuffer write data
we_in  in  1  write strobe, sampled on rising clk_in
disp_cs_n_o  out  1  LCD chip select, active low
disp_res_n_o  out  1  LCD reset, active low
disp_data_o  out  1  SPI MOSI, MSB first
disp_addr_o  out  1  LCD CD line: 0 = command, 1 = data
disp_sck_o  out  1  SPI clock, idle high

Behaviour:
- One clock, clk_in. reset_in is asynchronous and active-low. While reset_in=0, outputs are: cs_n=1, res_n=0, data=0, addr(CD)=0, sck=1. All engine state clears; framebuffer contents are kept (not reset; power-up value zero).
- Framebuffer: 960 x 16 RAM. Word a holds page p = a/120, columns c = 2*(a%120) (low byte) and c+1 (high byte). Bit n of each byte is row 8p+n.
- If we_in=1 and addr_in<960, data_in is written on that clock. Writes with addr_in>=960 are ignored. Writes are accepted in every state, including during reset sequencing.
- The framebuffer is read-first: if the engine reads the same word in the same cycle as a host write, the engine gets the old value.
- FSM sequence: RES_LOW (RST_LOW_CYCLES) -> RES_WAIT (RST_WAIT_CYCLES) -> INIT -> PAGE_CMD -> PAGE_DATA -> PAGE_CMD ...
- disp_res_n_o goes to 1 on entry to RES_WAIT and stays 1 until the next reset.
- INIT sends command bytes (CD=0) in order: F1 3F F2 00 F3 3F 81 B7 C0 02 A3 E9 A9 D1 89.
- PAGE_CMD, for page p (0..7), sends commands (CD=0): 60|(p&0xF), 70, 00, 10.
- PAGE_DATA sends 240 data bytes (CD=1) for columns 0..239: even column = low byte of the word, odd column = high byte.
- After page 7, the engine wraps to page 0 and refreshes continuously. INIT is never repeated.
- Byte transfer, with h = CLK_DIV clocks:
  - Cycle 0: cs_n falls, CD valid.
  - Then 8 bits, MSB first. Each bit: sck low for h clocks with data driven at the falling edge, then sck high for h clocks (panel samples on the rising edge).
  - After the last rising edge, cs_n returns high for 1 clock (gap).
  - Byte period = 2 + 16*h clocks (18 at default).
  - CD and data are stable while cs_n is low. sck is high whenever cs_n is high.
- reset_in asserted mid-byte aborts immediately to the reset output values. After release, the sequence restarts from RES_LOW.

Test Plan:
- Hold reset_in=0 for 500 ns, then release -> cs_n=1, sck=1, res_n=0 during reset; res_n rises exactly RST_LOW_CYCLES clocks after release; first cs_n fall follows RST_WAIT_CYCLES later.
- Capture SPI on rising sck with cs_n=0 -> first 15 bytes are F1 3F F2 00 F3 3F 81 B7 C0 02 A3 E9 A9 D1 89 with CD=0; each byte occupies 18 clocks at CLK_DIV=1.
- Empty framebuffer -> next bytes are 60 70 00 10 (CD=0), then 240 bytes of 00 (CD=1), then 61 70 00 10.
- Write addr 0 = 16'hA55A and addr 121 = 16'h1234 before page 0 -> page-0 data starts 5A A5; page-1 data bytes 2,3 are 34 12.
- Write addr 960 and 1023 with FFFF -> no output byte changes; frame stays all-zero.
- Assert reset_in mid-data-byte -> outputs return to reset values asynchronously; after release, the init sequence replays from F1 and framebuffer contents persist.
